// File: rtl/counter_en_core.sv
// Bounded up/down counter with enable; range is [min(A,B), max(A,B)].
// Define COUNTER_EN_CARRY_REG_EN for a registered Z_carry (default: combinational).
module counter_en_core #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_p,
   input  logic             EN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             D,
   output logic [WIDTH-1:0] Q,
   output logic             Z_carry
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] q_next;
   logic             in_range;
   logic             at_term;

   always_comb begin
      lo       = (A < B) ? A : B;
      hi       = (A < B) ? B : A;
      in_range = (Q >= lo) && (Q <= hi);
      at_term  = D ? (Q == lo) : (Q == hi);
      q_next   = Q;
      // Out-of-range reload and wrap both land on the entry bound for the direction
      if (!in_range || at_term) begin
         q_next = D ? hi : lo;
      end else if (D) begin
         q_next = Q - ONE;
      end else begin
         q_next = Q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_p) begin
         Q <= A;
      end else if (EN) begin
         Q <= q_next;
      end
   end

`ifdef COUNTER_EN_CARRY_REG_EN
   logic z_q;

   always_ff @(posedge clk) begin
      if (reset_p) begin
         z_q <= 1'b0;
      end else begin
         z_q <= EN && in_range && at_term;
      end
   end

   assign Z_carry = z_q;
`else
   assign Z_carry = EN && !reset_p && in_range && at_term;
`endif

endmodule

// File: tb/tb_counter_en_core.sv
// Scoreboard bench for counter_en_core: directed vectors push expected Q/wrap,
// a monitor pops and compares after each clock edge.
module tb_counter_en_core;

   localparam int unsigned W = 4;

   typedef struct {
      logic [W-1:0] q;
      logic         w;
   } exp_t;

   logic         clk;
   logic         reset_p;
   logic         EN;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         D;
   logic [W-1:0] Q;
   logic         Z_carry;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic z_pre;

   counter_en_core #(.WIDTH(W)) dut (
      .clk(clk),
      .reset_p(reset_p),
      .EN(EN),
      .A(A),
      .B(B),
      .D(D),
      .Q(Q),
      .Z_carry(Z_carry)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step(input logic r, input logic e, input logic dd,
                       input int unsigned a, input int unsigned b,
                       input int unsigned q, input logic w);
      exp_t x;
      logic [31:0] av;
      logic [31:0] bv;
      logic [31:0] qv;
      @(negedge clk);
      av = a;
      bv = b;
      qv = q;
      reset_p = r;
      EN      = e;
      D       = dd;
      A       = av[W-1:0];
      B       = bv[W-1:0];
      x.q     = qv[W-1:0];
      x.w     = w;
      sb.push_back(x);
   endtask

   // Monitor: capture combinational Z before the edge, Q (and registered Z) after it
   initial begin
      exp_t e;
      logic z_obs;
      forever begin
         @(negedge clk);
         #3;
         z_pre = Z_carry;
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (Q !== e.q) begin
               errors++;
               $display("FAIL q: got %0d expected %0d at %0t", Q, e.q, $time);
            end
`ifdef COUNTER_EN_CARRY_REG_EN
            z_obs = Z_carry;
`else
            z_obs = z_pre;
`endif
            checks++;
            if (z_obs !== e.w) begin
               errors++;
               $display("FAIL z_carry: got %b expected %b at %0t", z_obs, e.w, $time);
            end
         end
      end
   end

   initial begin
      bit drained;
      reset_p = 1'b1;
      EN      = 1'b1;
      D       = 1'b0;
      A       = 4'd4;
      B       = 4'd13;

      repeat (20) step(1, 1, 0, 4, 13, 4, 0);

      // up count with wrap 13 -> 4, then up to 9
      for (int v = 5; v <= 13; v++) step(0, 1, 0, 4, 13, v, 0);
      step(0, 1, 0, 4, 13, 4, 1);
      for (int v = 5; v <= 9; v++) step(0, 1, 0, 4, 13, v, 0);

      // direction flip at 9, wrap 4 -> 13, down to 7
      for (int v = 8; v >= 4; v--) step(0, 1, 1, 4, 13, v, 0);
      step(0, 1, 1, 4, 13, 13, 1);
      for (int v = 12; v >= 7; v--) step(0, 1, 1, 4, 13, v, 0);

      // hold at 7, then resume upward
      repeat (5) step(0, 0, 0, 4, 13, 7, 0);
      step(0, 1, 0, 4, 13, 8, 0);

      // swapped bounds behave identically
      for (int v = 9; v <= 13; v++) step(0, 1, 0, 13, 4, v, 0);
      step(0, 1, 0, 13, 4, 4, 1);
      step(0, 1, 0, 13, 4, 5, 0);

      // lower bound raised above Q: reload lo without a wrap event
      step(0, 1, 0, 8, 13, 8, 0);
      step(0, 1, 0, 8, 13, 9, 0);
      // upper bound dropped below Q while counting down: reload hi
      step(0, 1, 1, 4, 6, 6, 0);

      // degenerate range: every enabled edge is a wrap
      repeat (3) step(0, 1, 0, 6, 6, 6, 1);
      step(0, 1, 1, 6, 6, 6, 1);

      // mid-count reset loads A, then counting resumes
      step(1, 1, 0, 11, 6, 11, 0);
      step(0, 1, 0, 11, 6, 6, 1);
      step(0, 0, 1, 11, 6, 6, 0);
      step(0, 1, 1, 11, 6, 11, 1);

      drained = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0) begin
            drained = 1;
            break;
         end
      end
      if (!drained) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d entries left expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
